ex_issue: RTL

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/rv32_pkg.sv | 61 ++++++
 rtl/ex_issue_fwd_mux.sv | 30 +++
 rtl/ex_issue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 execute-side types: ALU operator, operand selects and the issue slot record.
// Also holds the bypass match rule so capture, refresh and output forwarding agree.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    OPA_RS1,
    OPA_PC,
    OPA_ZERO
  } op_a_sel_e;

  typedef enum logic {
    OPB_RS2,
    OPB_IMM
  } op_b_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    alu_op_e     alu_op;
    op_a_sel_e   sel_a;
    op_b_sel_e   sel_b;
  } slot_t;

  localparam slot_t SLOT_RESET = '{
    pc:       32'h0,
    rs1_addr: 5'd0,
    rs2_addr: 5'd0,
    rs1_data: 32'h0,
    rs2_data: 32'h0,
    imm:      32'h0,
    rd_addr:  5'd0,
    alu_op:   ALU_ADD,
    sel_a:    OPA_ZERO,
    sel_b:    OPB_IMM
  };

  // x0 is hardwired, so a write to it must never be bypassed.
  function automatic logic fwd_hit(input logic valid, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return valid && (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/ex_issue_fwd_mux.sv
// Per-source-register bypass select: EX result beats WB result beats the slot value.
// Purely combinational, no state and no flow control.
module fwd_mux
  import rv32_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]  rs_addr,
  input  logic [31:0] slot_data,
  input  logic        ex_fwd_valid,
  input  logic [4:0]  ex_fwd_rd,
  input  logic [31:0] ex_fwd_data,
  input  logic        wb_fwd_valid,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] rs_data
);

  always_comb begin
    rs_data = slot_data;
    if (FWD_EN) begin
      if (fwd_hit(ex_fwd_valid, ex_fwd_rd, rs_addr)) begin
        rs_data = ex_fwd_data;
      end else if (fwd_hit(wb_fwd_valid, wb_fwd_rd, rs_addr)) begin
        rs_data = wb_fwd_data;
      end
    end
  end

endmodule

// File: rtl/ex_issue.sv
// Single-slot issue register between decode and execute; one-cycle latency, full throughput.
// Decode is stalled only while the slot is full and execute is not consuming; flush empties the slot.
module ex_issue
  import rv32_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] id_pc_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rd_addr_i,
  input  alu_op_e     id_alu_op_i,
  input  op_a_sel_e   id_sel_a_i,
  input  op_b_sel_e   id_sel_b_i,
  input  logic        ex_fwd_valid_i,
  input  logic [4:0]  ex_fwd_rd_i,
  input  logic [31:0] ex_fwd_data_i,
  input  logic        wb_fwd_valid_i,
  input  logic [4:0]  wb_fwd_rd_i,
  input  logic [31:0] wb_fwd_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output alu_op_e     operator_o,
  output logic [31:0] ex_pc_o,
  output logic [4:0]  ex_rd_addr_o
);

  slot_t       slot_q;
  logic        slot_valid;
  logic        accept;
  logic        consume;
  logic [31:0] cap_rs1;
  logic [31:0] cap_rs2;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // During a flush the offered instruction is taken and dropped, so decode never stalls on it.
  assign id_ready_o = !slot_valid | ex_ready_i | flush_i;
  assign accept     = id_valid_i & id_ready_o & !flush_i;
  assign consume    = slot_valid & ex_ready_i & !flush_i;
  assign ex_valid_o = slot_valid & !flush_i;

  // The register file write lands in the same cycle, so its read data is stale on a match.
  assign cap_rs1 = (FWD_EN && fwd_hit(wb_fwd_valid_i, wb_fwd_rd_i, id_rs1_addr_i))
                   ? wb_fwd_data_i : id_rs1_data_i;
  assign cap_rs2 = (FWD_EN && fwd_hit(wb_fwd_valid_i, wb_fwd_rd_i, id_rs2_addr_i))
                   ? wb_fwd_data_i : id_rs2_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid <= 1'b0;
      slot_q     <= SLOT_RESET;
    end else if (flush_i) begin
      slot_valid <= 1'b0;
    end else if (accept) begin
      slot_valid      <= 1'b1;
      slot_q.pc       <= id_pc_i;
      slot_q.rs1_addr <= id_rs1_addr_i;
      slot_q.rs2_addr <= id_rs2_addr_i;
      slot_q.rs1_data <= cap_rs1;
      slot_q.rs2_data <= cap_rs2;
      slot_q.imm      <= id_imm_i;
      slot_q.rd_addr  <= id_rd_addr_i;
      slot_q.alu_op   <= id_alu_op_i;
      slot_q.sel_a    <= id_sel_a_i;
      slot_q.sel_b    <= id_sel_b_i;
    end else if (consume) begin
      slot_valid <= 1'b0;
    end else if (FWD_EN && slot_valid) begin
      // A stalled instruction absorbs writebacks it would otherwise miss once WB moves on.
      if (fwd_hit(wb_fwd_valid_i, wb_fwd_rd_i, slot_q.rs1_addr)) slot_q.rs1_data <= wb_fwd_data_i;
      if (fwd_hit(wb_fwd_valid_i, wb_fwd_rd_i, slot_q.rs2_addr)) slot_q.rs2_data <= wb_fwd_data_i;
    end
  end

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs_addr      (slot_q.rs1_addr),
    .slot_data    (slot_q.rs1_data),
    .ex_fwd_valid (ex_fwd_valid_i),
    .ex_fwd_rd    (ex_fwd_rd_i),
    .ex_fwd_data  (ex_fwd_data_i),
    .wb_fwd_valid (wb_fwd_valid_i),
    .wb_fwd_rd    (wb_fwd_rd_i),
    .wb_fwd_data  (wb_fwd_data_i),
    .rs_data      (rs1_fwd)
  );

  fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs_addr      (slot_q.rs2_addr),
    .slot_data    (slot_q.rs2_data),
    .ex_fwd_valid (ex_fwd_valid_i),
    .ex_fwd_rd    (ex_fwd_rd_i),
    .ex_fwd_data  (ex_fwd_data_i),
    .wb_fwd_valid (wb_fwd_valid_i),
    .wb_fwd_rd    (wb_fwd_rd_i),
    .wb_fwd_data  (wb_fwd_data_i),
    .rs_data      (rs2_fwd)
  );

  always_comb begin
    case (slot_q.sel_a)
      OPA_RS1: operand_a_o = rs1_fwd;
      OPA_PC:  operand_a_o = slot_q.pc;
      default: operand_a_o = 32'h0;
    endcase
  end

  assign operand_b_o  = (slot_q.sel_b == OPB_IMM) ? slot_q.imm : rs2_fwd;
  assign operator_o   = slot_q.alu_op;
  assign ex_pc_o      = slot_q.pc;
  assign ex_rd_addr_o = slot_q.rd_addr;

endmodule
